uart_output_decoder: RTL and testbench

Serial receive monitor for the SoC's UART transmit line. It deframes 8N1 characters from the `uart_tx` pin of the RISC-V subsystem and presents each received byte with a one-cycle valid strobe. In simulation it also echoes each byte to the console. It is a passive observer that never drives the line.

---
 rtl/uart_output_decoder.sv | 144 ++++++++++++++
 tb/tb_uart_output_decoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_output_decoder.sv
// Passive 8N1 receive monitor: deframes the observed serial line and presents
// each good byte with a one-cycle done strobe, or a one-cycle error strobe on a bad stop bit.
module uart_output_decoder #(
  parameter int CLK_HZ       = 74_250_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter bit SIM_PRINT    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_tx,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       uart_error
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  logic [1:0]    sync_r;
  logic          rx_s;
  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [7:0]    shift_r;
  logic [7:0]    data_r;
  logic          done_r;
  logic          err_r;

  assign rx_s       = sync_r[1];
  assign uart_data  = data_r;
  assign uart_done  = done_r;
  assign uart_error = err_r;

  // Two-flop synchronizer for the asynchronous line; resets to the idle-high level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], uart_tx};
    end
  end

  // Deframing FSM; strobes default low so each one lasts exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      data_r  <= 8'h00;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= CNT_ZERO;
          if (!rx_s) begin
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r   <= CNT_ZERO;
            idx_r   <= 3'd0;
            // A line that is high again at mid-start was only a glitch.
            state_r <= rx_s ? IDLE : DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_r == FULL_LAST) begin
            cnt_r          <= CNT_ZERO;
            shift_r[idx_r] <= rx_s;
            if (idx_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_r == FULL_LAST) begin
            cnt_r <= CNT_ZERO;
            if (rx_s) begin
              data_r  <= shift_r;
              done_r  <= 1'b1;
              state_r <= IDLE;
            end else begin
              err_r   <= 1'b1;
              state_r <= WAIT_HIGH;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          cnt_r <= CNT_ZERO;
          if (rx_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_HIGH;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  generate
    if (SIM_PRINT) begin : g_print
      // Console echo of each good byte, sampled while the done strobe is high.
      always @(posedge clk) begin
        if (uart_done) begin
          $write("%c", uart_data);
        end
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_uart_output_decoder.sv
// Directed bench for uart_output_decoder at 16 clocks per bit.
module tb_uart_output_decoder;

  localparam int NB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_tx = 1'b1;
  logic [7:0] uart_data;
  logic       uart_done;
  logic       uart_error;

  int   cyc = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   viol_cnt = 0;
  int   done_cyc = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] rx_q[$];

  int   total = 0;
  int   passed = 0;
  int   start_cyc;
  int   base_done;
  int   base_err;

  uart_output_decoder #(
    .CLK_HZ(1_600_000),
    .BAUD(100_000),
    .SIM_PRINT(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .uart_tx(uart_tx),
    .uart_data(uart_data),
    .uart_done(uart_done),
    .uart_error(uart_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (uart_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      rx_q.push_back(uart_data);
    end
    if (uart_error) err_cnt <= err_cnt + 1;
    if (uart_done && uart_error) viol_cnt <= viol_cnt + 1;
    if ((uart_done || uart_error) && prev_strobe) viol_cnt <= viol_cnt + 1;
    prev_strobe <= uart_done || uart_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    uart_tx = b;
    repeat (NB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  initial begin
    // 1. reset behaviour
    @(negedge clk);
    reset = 1'b0;
    uart_tx = 1'b1;
    idle(8);
    check("rst_data", {24'h0, uart_data}, 32'h00);
    check("rst_done", {31'h0, uart_done}, 32'h0);
    check("rst_error", {31'h0, uart_error}, 32'h0);
    reset = 1'b1;
    idle(100);
    check("idle_done_cnt", done_cnt, 0);
    check("idle_err_cnt", err_cnt, 0);

    // 2. single byte with latency
    start_cyc = cyc;
    send_frame(8'h48, 1'b1);
    idle(20);
    check("single_done_cnt", done_cnt, 1);
    check("single_q0", {24'h0, rx_q[0]}, 32'h48);
    check("single_data", {24'h0, uart_data}, 32'h48);
    check("single_latency", done_cyc - start_cyc, 155);

    // 3. back-to-back "Hi\n"
    send_frame(8'h48, 1'b1);
    send_frame(8'h69, 1'b1);
    send_frame(8'h0A, 1'b1);
    idle(20);
    check("b2b_done_cnt", done_cnt, 4);
    check("b2b_q1", {24'h0, rx_q[1]}, 32'h48);
    check("b2b_q2", {24'h0, rx_q[2]}, 32'h69);
    check("b2b_q3", {24'h0, rx_q[3]}, 32'h0A);
    check("b2b_err_cnt", err_cnt, 0);

    // 4. glitch rejection
    uart_tx = 1'b0;
    idle(3);
    uart_tx = 1'b1;
    idle(40);
    check("glitch_done_cnt", done_cnt, 4);
    check("glitch_err_cnt", err_cnt, 0);
    send_frame(8'h55, 1'b1);
    idle(20);
    check("post_glitch_cnt", done_cnt, 5);
    check("post_glitch_data", {24'h0, uart_data}, 32'h55);

    // 5. framing error then break
    send_frame(8'hA5, 1'b0);
    idle(40);
    check("ferr_err_cnt", err_cnt, 1);
    check("ferr_done_cnt", done_cnt, 5);
    check("ferr_data_kept", {24'h0, uart_data}, 32'h55);
    uart_tx = 1'b1;
    idle(30);
    check("ferr_quiet_done", done_cnt, 5);
    check("ferr_quiet_err", err_cnt, 1);
    send_frame(8'h31, 1'b1);
    idle(20);
    check("ferr_next_cnt", done_cnt, 6);
    check("ferr_next_data", {24'h0, uart_data}, 32'h31);

    // 6. reset during data bit 4 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    uart_tx = 1'b1;
    idle(8);
    reset = 1'b0;
    idle(4);
    reset = 1'b1;
    idle(40);
    check("midrst_done_cnt", done_cnt, 6);
    check("midrst_err_cnt", err_cnt, 1);
    check("midrst_data", {24'h0, uart_data}, 32'h00);
    send_frame(8'h00, 1'b1);
    idle(20);
    check("zero_done_cnt", done_cnt, 7);
    check("zero_data", {24'h0, uart_data}, 32'h00);
    check("zero_q", {24'h0, rx_q[6]}, 32'h00);

    check("strobe_rules", viol_cnt, 0);

    $display("");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
